// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the hard-wired control sequencer: state encoding,
// instruction-register field positions, opcode constants and ALU op indices.
package ctrl_sequencer_pkg;

   // Sequencer states: fetch T0-T2, execute T3-T5, plus idle and halt.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_T5   = 3'd6,
      ST_HALT = 3'd7
   } state_e;

   // Instruction register field positions.
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 27;
   localparam int unsigned RA_MSB  = 26;
   localparam int unsigned RA_LSB  = 23;
   localparam int unsigned RB_MSB  = 22;
   localparam int unsigned RB_LSB  = 19;
   localparam int unsigned RC_MSB  = 18;
   localparam int unsigned RC_LSB  = 15;

   // Opcode constants; ALU opcodes occupy 0..7 and map directly to AluOp bit index.
   localparam logic [4:0] OPC_ADD  = 5'b00000;
   localparam logic [4:0] OPC_SUB  = 5'b00001;
   localparam logic [4:0] OPC_AND  = 5'b00010;
   localparam logic [4:0] OPC_ROR  = 5'b00011;
   localparam logic [4:0] OPC_ROL  = 5'b00100;
   localparam logic [4:0] OPC_SHR  = 5'b00101;
   localparam logic [4:0] OPC_SHL  = 5'b00110;
   localparam logic [4:0] OPC_OR   = 5'b00111;
   localparam logic [4:0] OPC_HALT = 5'b11111;

   // AluOp one-hot bit indices.
   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_AND = 2;
   localparam int unsigned ALU_ROR = 3;
   localparam int unsigned ALU_ROL = 4;
   localparam int unsigned ALU_SHR = 5;
   localparam int unsigned ALU_SHL = 6;
   localparam int unsigned ALU_OR  = 7;

   // True for the three-register ALU opcodes (ADD..OR).
   function automatic logic opc_is_alu(input logic [4:0] opc);
      return (opc <= OPC_OR);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_reg_field_decoder.sv
// Converts a 4-bit register field into a one-hot general-register strobe.
// Fields that address a register beyond NREG produce no strobe.
module reg_field_decoder #(
   parameter int unsigned NREG = 16
) (
   input  logic [3:0]      field_i,
   input  logic            en_i,
   output logic [NREG-1:0] onehot_o
);

   // One-hot decode of the field, gated by enable and range.
   always_comb begin
      onehot_o = '0;
      if (en_i && (32'(field_i) < NREG)) begin
         onehot_o[field_i] = 1'b1;
      end else begin
         onehot_o = '0;
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hard-wired control sequencer: fetch (T0-T2) and execute (T3-T5) for
// three-register ALU instructions, with memory wait states, halt and
// illegal-opcode handling. Strobes are decoded from the registered state.
module ctrl_sequencer
   import ctrl_sequencer_pkg::*;
#(
   parameter int unsigned NREG        = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic            clock_i,
   input  logic            clear_i,
   input  logic            run_i,
   input  logic [31:0]     ir_i,
   input  logic            mem_rdy_i,
   output logic            pc_out_o,
   output logic            zlow_out_o,
   output logic            mdr_out_o,
   output logic            mar_in_o,
   output logic            pc_in_o,
   output logic            mdr_in_o,
   output logic            ir_in_o,
   output logic            y_in_o,
   output logic            z_in_o,
   output logic            inc_pc_o,
   output logic            read_o,
   output logic [NREG-1:0] rout_o,
   output logic [NREG-1:0] rin_o,
   output logic [7:0]      alu_op_o,
   output logic            halted_o,
   output logic            illegal_o,
   output logic            bus_err_o
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       illegal_q, illegal_d;
   logic       bus_err_q, bus_err_d;

   logic [4:0] opcode_s;
   logic [3:0] ra_s, rb_s, rc_s, rout_sel_s;
   logic       fields_ok_s, opc_legal_s, rout_en_s, rin_en_s;
   logic       unused_ir_s;

   assign opcode_s    = ir_i[OPC_MSB:OPC_LSB];
   assign ra_s        = ir_i[RA_MSB:RA_LSB];
   assign rb_s        = ir_i[RB_MSB:RB_LSB];
   assign rc_s        = ir_i[RC_MSB:RC_LSB];
   assign unused_ir_s = ^ir_i[14:0];

   // An ALU instruction is only legal if every register field names a real register.
   assign fields_ok_s = (32'(ra_s) < NREG) && (32'(rb_s) < NREG) && (32'(rc_s) < NREG);
   assign opc_legal_s = opc_is_alu(opcode_s) && fields_ok_s;

   // State, wait counter and event-pulse registers.
   always_ff @(posedge clock_i or negedge clear_i) begin
      if (!clear_i) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 8'd0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Next-state logic; the wait counter only advances while stalled in T1.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = 8'd0;
      illegal_d  = 1'b0;
      bus_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_i) state_d = ST_T0;
            else       state_d = ST_IDLE;
         end
         ST_T0: state_d = ST_T1;
         ST_T1: begin
            if (mem_rdy_i) begin
               state_d = ST_T2;
            end else if (wait_cnt_q >= WAIT_LAST) begin
               state_d   = ST_IDLE;
               bus_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_T2: state_d = ST_T3;
         ST_T3: begin
            if (opc_legal_s) begin
               state_d = ST_T4;
            end else if (opcode_s == OPC_HALT) begin
               state_d = ST_HALT;
            end else begin
               illegal_d = 1'b1;
               state_d   = run_i ? ST_T0 : ST_IDLE;
            end
         end
         ST_T4: state_d = ST_T5;
         ST_T5: begin
            if (run_i) state_d = ST_T0;
            else       state_d = ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobe decode from the registered state (Moore).
   always_comb begin
      pc_out_o   = 1'b0;
      zlow_out_o = 1'b0;
      mdr_out_o  = 1'b0;
      mar_in_o   = 1'b0;
      pc_in_o    = 1'b0;
      mdr_in_o   = 1'b0;
      ir_in_o    = 1'b0;
      y_in_o     = 1'b0;
      z_in_o     = 1'b0;
      inc_pc_o   = 1'b0;
      read_o     = 1'b0;
      alu_op_o   = 8'd0;
      case (state_q)
         ST_T0: begin
            pc_out_o = 1'b1;
            mar_in_o = 1'b1;
            inc_pc_o = 1'b1;
            z_in_o   = 1'b1;
         end
         ST_T1: begin
            zlow_out_o = 1'b1;
            pc_in_o    = 1'b1;
            read_o     = 1'b1;
            mdr_in_o   = 1'b1;
         end
         ST_T2: begin
            mdr_out_o = 1'b1;
            ir_in_o   = 1'b1;
         end
         ST_T3: y_in_o = 1'b1;
         ST_T4: begin
            z_in_o   = 1'b1;
            alu_op_o = 8'd1 << opcode_s[2:0];
         end
         ST_T5: zlow_out_o = 1'b1;
         default: alu_op_o = 8'd0;
      endcase
   end

   // rb drives the bus in T3, rc in T4; ra is written in T5.
   assign rout_sel_s = (state_q == ST_T4) ? rc_s : rb_s;
   assign rout_en_s  = (state_q == ST_T3) || (state_q == ST_T4);
   assign rin_en_s   = (state_q == ST_T5);

   reg_field_decoder #(.NREG(NREG)) u_rout_dec (
      .field_i  (rout_sel_s),
      .en_i     (rout_en_s),
      .onehot_o (rout_o)
   );

   reg_field_decoder #(.NREG(NREG)) u_rin_dec (
      .field_i  (ra_s),
      .en_i     (rin_en_s),
      .onehot_o (rin_o)
   );

   assign halted_o  = (state_q == ST_HALT);
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with hand-computed strobe expectations.
module tb_ctrl_sequencer;

   logic        clock, clear, run, mem_rdy;
   logic [31:0] ir;
   logic        pc_out, zlow_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
   logic        y_in, z_in, inc_pc, read, halted, illegal, bus_err;
   logic [15:0] rout, rin;
   logic [7:0]  alu_op;
   logic [10:0] strobes;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   // Strobe bit order: pc_out zlow mdr_out mar_in pc_in mdr_in ir_in y_in z_in inc_pc read
   localparam logic [10:0] S_NONE = 11'h000;
   localparam logic [10:0] S_T0   = 11'h486;
   localparam logic [10:0] S_T1   = 11'h261;
   localparam logic [10:0] S_T2   = 11'h110;
   localparam logic [10:0] S_T3   = 11'h008;
   localparam logic [10:0] S_T4   = 11'h004;
   localparam logic [10:0] S_T5   = 11'h200;

   assign strobes = {pc_out, zlow_out, mdr_out, mar_in, pc_in, mdr_in, ir_in,
                     y_in, z_in, inc_pc, read};

   ctrl_sequencer #(.NREG(16), .MEM_TIMEOUT(15)) dut (
      .clock_i    (clock),
      .clear_i    (clear),
      .run_i      (run),
      .ir_i       (ir),
      .mem_rdy_i  (mem_rdy),
      .pc_out_o   (pc_out),
      .zlow_out_o (zlow_out),
      .mdr_out_o  (mdr_out),
      .mar_in_o   (mar_in),
      .pc_in_o    (pc_in),
      .mdr_in_o   (mdr_in),
      .ir_in_o    (ir_in),
      .y_in_o     (y_in),
      .z_in_o     (z_in),
      .inc_pc_o   (inc_pc),
      .read_o     (read),
      .rout_o     (rout),
      .rin_o      (rin),
      .alu_op_o   (alu_op),
      .halted_o   (halted),
      .illegal_o  (illegal),
      .bus_err_o  (bus_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [10:0] s_exp,
                             input logic [15:0] rout_exp, input logic [15:0] rin_exp,
                             input logic [7:0] alu_exp, input logic halt_exp,
                             input logic ill_exp, input logic berr_exp);
      check_eq({tag, ".strobes"}, 32'(strobes), 32'(s_exp));
      check_eq({tag, ".rout"},    32'(rout),    32'(rout_exp));
      check_eq({tag, ".rin"},     32'(rin),     32'(rin_exp));
      check_eq({tag, ".aluop"},   32'(alu_op),  32'(alu_exp));
      check_eq({tag, ".halted"},  32'(halted),  32'(halt_exp));
      check_eq({tag, ".illegal"}, 32'(illegal), 32'(ill_exp));
      check_eq({tag, ".bus_err"}, 32'(bus_err), 32'(berr_exp));
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b0; run = 1'b0; mem_rdy = 1'b0; ir = 32'h0;
      #12;
      expect_out("reset", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      clear = 1'b1;
      tick; tick;
      expect_out("idle_run0", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);

      // ROR r5 <- r2, r4 with no memory wait
      ir = 32'h1A920000; mem_rdy = 1'b1; run = 1'b1;
      tick; expect_out("ror.T0", S_T0, 16'h0,    16'h0,    8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ror.T1", S_T1, 16'h0,    16'h0,    8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ror.T2", S_T2, 16'h0,    16'h0,    8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ror.T3", S_T3, 16'h0004, 16'h0,    8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ror.T4", S_T4, 16'h0010, 16'h0,    8'h08, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ror.T5", S_T5, 16'h0,    16'h0020, 8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ror.T0b", S_T0, 16'h0,   16'h0,    8'h00, 1'b0, 1'b0, 1'b0);

      // Clear asserted mid-T4 abandons the instruction at once
      tick; tick; tick; tick;
      expect_out("clr.T4", S_T4, 16'h0010, 16'h0, 8'h08, 1'b0, 1'b0, 1'b0);
      #2 clear = 1'b0;
      #1 expect_out("clr.async", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
      #3 clear = 1'b1;
      tick; tick;
      expect_out("clr.idle", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Three memory wait cycles; Run dropped mid-instruction
      mem_rdy = 1'b0; run = 1'b1;
      tick; expect_out("wait.T0", S_T0, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
      tick; expect_out("wait.T1a", S_T1, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick; tick; tick;
      expect_out("wait.T1d", S_T1, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      mem_rdy = 1'b1;
      tick; expect_out("wait.T2", S_T2, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick; tick;
      expect_out("wait.T4", S_T4, 16'h0010, 16'h0, 8'h08, 1'b0, 1'b0, 1'b0);
      tick; tick;
      expect_out("wait.stop", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Memory never ready: 15 wait cycles then bus error
      mem_rdy = 1'b0; run = 1'b1;
      tick; run = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick;
         expect_out($sformatf("tmo.T1_%0d", i), S_T1, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      tick; expect_out("tmo.berr", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick; expect_out("tmo.after", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Undefined opcode 01010
      ir = 32'h50000000; mem_rdy = 1'b1; run = 1'b1;
      tick; tick; tick; tick;
      expect_out("ill.T3", S_T3, 16'h0001, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("ill.T0", S_T0, 16'h0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0);
      tick; expect_out("ill.T1", S_T1, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      ir = 32'h00000000; run = 1'b0;
      tick; tick;
      expect_out("add.T3", S_T3, 16'h0001, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("add.T4", S_T4, 16'h0001, 16'h0, 8'h01, 1'b0, 1'b0, 1'b0);
      tick; expect_out("add.T5", S_T5, 16'h0, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);
      tick; expect_out("add.idle", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);

      // HALT holds despite Run until Clear
      ir = 32'hF8000000; run = 1'b1;
      tick; tick; tick; tick;
      for (int i = 0; i < 20; i++) begin
         tick;
         expect_out($sformatf("halt_%0d", i), S_NONE, 16'h0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      clear = 1'b0;
      #1 expect_out("halt.clr", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      clear = 1'b1; run = 1'b0;
      tick; expect_out("halt.idle", S_NONE, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
